// File: rtl/vga_timing_pkg.sv
// Purpose: default raster mode (640x480@60) and helpers for timing totals and counter width.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Full period of one axis: visible region plus all blanking segments.
  function automatic int unsigned calc_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Bits needed to hold 0..max(h_total, v_total)-1.
  function automatic int unsigned calc_cw(input int unsigned h_total,
                                          input int unsigned v_total);
    int unsigned m;
    m = (h_total > v_total) ? h_total : v_total;
    return $clog2(m);
  endfunction

  localparam int unsigned DEF_CW =
    calc_cw(calc_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP),
            calc_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP));

endpackage

// File: rtl/vga_axis_counter.sv
// Purpose: one raster axis: wrapping position counter with registered sync and next-state active flag.
// Latency: count/sync update on the clk edge where tick_i=1; next-state outputs are combinational.
// Backpressure: none; tick_i=0 simply holds the position.
module vga_axis_counter #(
  parameter int unsigned CW         = 10,
  parameter int unsigned WRAP       = 799,
  parameter int unsigned SYNC_START = 656,
  parameter int unsigned SYNC_END   = 752,
  parameter int unsigned ACT_END    = 640,
  parameter bit          POL        = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick_i,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] count_nxt_o,
  output logic          wrap_o,
  output logic          sync_o,
  output logic          active_nxt_o
);

  localparam logic [CW-1:0] WRAP_C = CW'(WRAP);
  localparam logic [CW-1:0] SS_C   = CW'(SYNC_START);
  localparam logic [CW-1:0] SE_C   = CW'(SYNC_END);
  localparam logic [CW-1:0] ACT_C  = CW'(ACT_END);

  logic [CW-1:0] count_q, count_d;
  logic          sync_q, sync_d;

  assign wrap_o = (count_q == WRAP_C);

  // Next position and the sync level that position implies.
  always_comb begin
    count_d = count_q;
    if (tick_i) begin
      count_d = wrap_o ? '0 : count_q + 1'b1;
    end
    sync_d = ((count_d >= SS_C) && (count_d < SE_C)) ? POL : ~POL;
  end

  // Reset parks the axis on its last position, which lies in the back porch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= WRAP_C;
      sync_q  <= ~POL;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
    end
  end

  assign count_o      = count_q;
  assign count_nxt_o  = count_d;
  assign sync_o       = sync_q;
  assign active_nxt_o = (count_d < ACT_C);

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: parametrised raster timing generator (position, syncs, display enable, line/frame/animate strobes).
// Latency: every output registered, valid one clk edge after the advancing pix_en edge.
// Backpressure: none; pix_en=0 freezes position, strobes drop on the next clk edge.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          h_sync,
  output logic          v_sync,
  output logic          display,
  output logic          line_start,
  output logic          frame_start,
  output logic          animate
);

  localparam int unsigned H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);

  logic [CW-1:0] x_nxt, y_nxt;
  logic          h_wrap, v_wrap, h_act_nxt, v_act_nxt, v_tick;
  logic          display_q, display_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          animate_q, animate_d;

  // Vertical axis steps only when the horizontal axis wraps on an advancing edge.
  assign v_tick = pix_en & h_wrap;

  vga_axis_counter #(
    .CW(CW), .WRAP(H_TOTAL - 1), .SYNC_START(H_ACTIVE + H_FP),
    .SYNC_END(H_ACTIVE + H_FP + H_SYNC), .ACT_END(H_ACTIVE), .POL(H_POL)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .tick_i(pix_en),
    .count_o(x), .count_nxt_o(x_nxt), .wrap_o(h_wrap),
    .sync_o(h_sync), .active_nxt_o(h_act_nxt)
  );

  vga_axis_counter #(
    .CW(CW), .WRAP(V_TOTAL - 1), .SYNC_START(V_ACTIVE + V_FP),
    .SYNC_END(V_ACTIVE + V_FP + V_SYNC), .ACT_END(V_ACTIVE), .POL(V_POL)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .tick_i(v_tick),
    .count_o(y), .count_nxt_o(y_nxt), .wrap_o(v_wrap),
    .sync_o(v_sync), .active_nxt_o(v_act_nxt)
  );

  // Strobes fire only when an advancing edge lands on their position.
  always_comb begin
    display_d     = h_act_nxt & v_act_nxt;
    line_start_d  = pix_en & (x_nxt == '0);
    frame_start_d = line_start_d & v_wrap;
    animate_d     = line_start_d & (y_nxt == V_ACT_C);
  end

  // Register display and strobes so they line up with the registered x/y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      animate_q     <= 1'b0;
    end else begin
      display_q     <= display_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      animate_q     <= animate_d;
    end
  end

  assign display     = display_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign animate     = animate_q;

endmodule
